quad_encoder_mc: RTL and testbench

// Multi-channel quadrature encoder front end for the PmodENC/AXI peripheral family: NUM_CH

---
 rtl/quad_encoder_mc_if.sv | 31 +++
 rtl/quad_encoder_mc.sv | 206 ++++++++++++++++++++
 tb/tb_quad_encoder_mc.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/quad_encoder_mc_if.sv
// Encoder front-end bus: raw encoder pins, control pulses, config and decoded outputs.
interface quad_encoder_mc_if #(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned CNTR_WIDTH = 16
);
  logic [NUM_CH-1:0]            enc_a;
  logic [NUM_CH-1:0]            enc_b;
  logic [NUM_CH-1:0]            clear_count;
  logic                         load_config;
  logic [1:0]                   cfg_mode;
  logic [3:0]                   cfg_step;
  logic                         cfg_wrap;
  logic [CNTR_WIDTH-1:0]        cfg_min;
  logic [CNTR_WIDTH-1:0]        cfg_max;
  logic [NUM_CH-1:0]            enc_event;
  logic [NUM_CH-1:0]            enc_left;
  logic [NUM_CH-1:0]            enc_err;
  logic [NUM_CH*CNTR_WIDTH-1:0] count;

  modport master (
    output enc_a, enc_b, clear_count, load_config,
    output cfg_mode, cfg_step, cfg_wrap, cfg_min, cfg_max,
    input  enc_event, enc_left, enc_err, count
  );

  modport slave (
    input  enc_a, enc_b, clear_count, load_config,
    input  cfg_mode, cfg_step, cfg_wrap, cfg_min, cfg_max,
    output enc_event, enc_left, enc_err, count
  );
endinterface

// File: rtl/quad_encoder_mc.sv
// quad_encoder_mc: NUM_CH quadrature channels, each synchronised, glitch-filtered and
// decoded (x1/x2/x4) into a signed count with programmable step and saturate/wrap limits.
module quad_encoder_mc #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNTR_WIDTH  = 16,
  parameter int unsigned FILT_CYCLES = 4,
  parameter int unsigned DFLT_MODE   = 2,
  parameter int unsigned DFLT_STEP   = 1,
  parameter int unsigned DFLT_WRAP   = 0
) (
  input  logic             clk,
  input  logic             reset,
  quad_encoder_mc_if.slave bus
);

  localparam int unsigned CW = CNTR_WIDTH;
  localparam int unsigned EW = CNTR_WIDTH + 2;
  localparam int unsigned FW = 8;
  localparam logic [FW-1:0]        FILT_LAST = FW'(FILT_CYCLES - 1);
  localparam logic signed [CW-1:0] ZERO      = '0;
  localparam logic signed [CW-1:0] MOST_NEG  = {1'b1, {(CW-1){1'b0}}};
  localparam logic signed [CW-1:0] MOST_POS  = {1'b0, {(CW-1){1'b1}}};
  localparam logic signed [EW-1:0] ONE_E     = EW'(1);

  // Zero clamped into [lo,hi]; callers guarantee lo <= hi.
  function automatic logic signed [CW-1:0] clamp_zero(input logic signed [CW-1:0] lo,
                                                      input logic signed [CW-1:0] hi);
    if (lo > ZERO) return lo;
    if (hi < ZERO) return hi;
    return ZERO;
  endfunction

  // Position of a {B,A} pair along the increment sequence 00->01->11->10.
  function automatic logic [1:0] gray_idx(input logic [1:0] p);
    return {p[1], p[1] ^ p[0]};
  endfunction

  logic [1:0]           mode_q, mode_d;
  logic [3:0]           step_q, step_d;
  logic                 wrap_q, wrap_d;
  logic signed [CW-1:0] min_q, min_d;
  logic signed [CW-1:0] max_q, max_d;
  logic                 load_ok_c;
  logic signed [CW-1:0] ld_zero_c;
  logic signed [CW-1:0] clr_zero_c;

  logic [NUM_CH-1:0]    ev_v;
  logic [NUM_CH-1:0]    left_v;
  logic [NUM_CH-1:0]    err_v;
  logic [NUM_CH*CW-1:0] cnt_v;

  // Shared configuration: an inverted range makes the whole load a no-op.
  always_comb begin
    mode_d     = mode_q;
    step_d     = step_q;
    wrap_d     = wrap_q;
    min_d      = min_q;
    max_d      = max_q;
    load_ok_c  = bus.load_config && ($signed(bus.cfg_min) <= $signed(bus.cfg_max));
    ld_zero_c  = clamp_zero($signed(bus.cfg_min), $signed(bus.cfg_max));
    clr_zero_c = clamp_zero(min_q, max_q);
    if (load_ok_c) begin
      mode_d = bus.cfg_mode;
      step_d = bus.cfg_step;
      wrap_d = bus.cfg_wrap;
      min_d  = $signed(bus.cfg_min);
      max_d  = $signed(bus.cfg_max);
    end
  end

  // Configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= 2'(DFLT_MODE);
      step_q <= 4'(DFLT_STEP);
      wrap_q <= 1'(DFLT_WRAP);
      min_q  <= MOST_NEG;
      max_q  <= MOST_POS;
    end else begin
      mode_q <= mode_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      min_q  <= min_d;
      max_q  <= max_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [1:0]           sync1_q, sync2_q;
    logic [1:0]           cand_q, cand_d;
    logic [1:0]           filt_q, filt_d;
    logic [FW-1:0]        fcnt_q, fcnt_d;
    logic signed [CW-1:0] cnt_q, cnt_d;
    logic                 ev_q, ev_d;
    logic                 left_q, left_d;
    logic                 err_q, err_d;
    logic                 accept_c, illegal_c, up_c, dn_c;
    logic [1:0]           prev_idx_c, delta_c;
    logic signed [EW-1:0] cur_e, step_e, min_e, max_e, sum_e, res_e;

    // Stability filter: the candidate pair must hold FILT_CYCLES cycles to be accepted.
    always_comb begin
      cand_d   = cand_q;
      fcnt_d   = fcnt_q;
      filt_d   = filt_q;
      accept_c = 1'b0;
      if (sync2_q != cand_q) begin
        cand_d = sync2_q;
        fcnt_d = '0;
      end else if (fcnt_q < FILT_LAST) begin
        fcnt_d = fcnt_q + FW'(1);
      end else if (filt_q != cand_q) begin
        accept_c = 1'b1;
        filt_d   = cand_q;
      end
    end

    // Direction decode and x1/x2/x4 qualification of an accepted transition.
    always_comb begin
      prev_idx_c = gray_idx(filt_q);
      delta_c    = gray_idx(cand_q) - prev_idx_c;
      illegal_c  = accept_c && (delta_c == 2'd2);
      up_c       = 1'b0;
      dn_c       = 1'b0;
      if (mode_q[1]) begin
        up_c = accept_c && (delta_c == 2'd1);
        dn_c = accept_c && (delta_c == 2'd3);
      end else if (mode_q[0]) begin
        up_c = accept_c && (delta_c == 2'd1) && prev_idx_c[0];
        dn_c = accept_c && (delta_c == 2'd3) && !prev_idx_c[0];
      end else begin
        up_c = accept_c && (delta_c == 2'd1) && (prev_idx_c == 2'd3);
        dn_c = accept_c && (delta_c == 2'd3) && (prev_idx_c == 2'd0);
      end
    end

    // Widened step arithmetic with saturate or single-fold wrap at the limits.
    always_comb begin
      cur_e  = EW'(cnt_q);
      step_e = EW'($signed({1'b0, step_q}));
      min_e  = EW'(min_q);
      max_e  = EW'(max_q);
      sum_e  = dn_c ? (cur_e - step_e) : (cur_e + step_e);
      res_e  = sum_e;
      if (sum_e > max_e) begin
        res_e = wrap_q ? (min_e + (sum_e - max_e - ONE_E)) : max_e;
      end else if (sum_e < min_e) begin
        res_e = wrap_q ? (max_e - (min_e - sum_e - ONE_E)) : min_e;
      end
    end

    // Output/count next state: clear beats load beats step; events always pulse.
    always_comb begin
      ev_d   = up_c || dn_c;
      left_d = left_q;
      err_d  = err_q;
      cnt_d  = cnt_q;
      if (up_c || dn_c) left_d = dn_c;
      if (illegal_c) err_d = 1'b1;
      if (bus.clear_count[g]) begin
        cnt_d = clr_zero_c;
        err_d = 1'b0;
      end else if (load_ok_c) begin
        cnt_d = ld_zero_c;
      end else if (up_c || dn_c) begin
        cnt_d = CW'(res_e);
      end
    end

    // Per-channel synchroniser, filter and output registers.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q <= '0;
        sync2_q <= '0;
        cand_q  <= '0;
        filt_q  <= '0;
        fcnt_q  <= '0;
        cnt_q   <= ZERO;
        ev_q    <= 1'b0;
        left_q  <= 1'b0;
        err_q   <= 1'b0;
      end else begin
        sync1_q <= {bus.enc_b[g], bus.enc_a[g]};
        sync2_q <= sync1_q;
        cand_q  <= cand_d;
        filt_q  <= filt_d;
        fcnt_q  <= fcnt_d;
        cnt_q   <= cnt_d;
        ev_q    <= ev_d;
        left_q  <= left_d;
        err_q   <= err_d;
      end
    end

    assign ev_v[g]                = ev_q;
    assign left_v[g]              = left_q;
    assign err_v[g]               = err_q;
    assign cnt_v[g*CW +: CW]      = cnt_q;
  end

  assign bus.enc_event = ev_v;
  assign bus.enc_left  = left_v;
  assign bus.enc_err   = err_v;
  assign bus.count     = cnt_v;

endmodule

// File: tb/tb_quad_encoder_mc.sv
// Directed bench for quad_encoder_mc: two channels, 16-bit counts, FILT_CYCLES=4.
module tb_quad_encoder_mc;
  localparam int unsigned NCH = 2;
  localparam int unsigned CW  = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  quad_encoder_mc_if #(.NUM_CH(NCH), .CNTR_WIDTH(CW)) bus_if ();

  quad_encoder_mc #(
    .NUM_CH(NCH), .CNTR_WIDTH(CW), .FILT_CYCLES(4),
    .DFLT_MODE(2), .DFLT_STEP(1), .DFLT_WRAP(0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int ev_tot [NCH];
  int e0, e1;

  // Running count of enc_event pulses per channel.
  always @(negedge clk) begin
    for (int i = 0; i < NCH; i++) ev_tot[i] <= ev_tot[i] + int'(bus_if.enc_event[i]);
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] cnt(input int ch);
    logic signed [CW-1:0] v;
    v = bus_if.count[ch*CW +: CW];
    return 64'(v);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int ch, input logic [1:0] p);
    bus_if.enc_a[ch] = p[0];
    bus_if.enc_b[ch] = p[1];
  endtask

  task automatic move(input int ch, input logic [1:0] p);
    drive(ch, p);
    tick(9);
  endtask

  task automatic load(input logic [1:0] m, input logic [3:0] s, input logic w,
                      input logic signed [CW-1:0] lo, input logic signed [CW-1:0] hi);
    bus_if.cfg_mode    = m;
    bus_if.cfg_step    = s;
    bus_if.cfg_wrap    = w;
    bus_if.cfg_min     = lo;
    bus_if.cfg_max     = hi;
    bus_if.load_config = 1'b1;
    tick(1);
    bus_if.load_config = 1'b0;
  endtask

  logic [1:0] rseq [4];
  logic [1:0] lseq [4];
  int         exp_sat  [4];
  int         exp_wrap [5];

  initial begin
    rseq     = '{2'b01, 2'b11, 2'b10, 2'b00};
    lseq     = '{2'b10, 2'b11, 2'b01, 2'b00};
    exp_sat  = '{3, 5, 5, 5};
    exp_wrap = '{3, -2, 1, 4, -1};

    reset              = 1'b1;
    bus_if.enc_a       = '0;
    bus_if.enc_b       = '0;
    bus_if.clear_count = '0;
    bus_if.load_config = 1'b0;
    bus_if.cfg_mode    = 2'd2;
    bus_if.cfg_step    = 4'd1;
    bus_if.cfg_wrap    = 1'b0;
    bus_if.cfg_min     = '0;
    bus_if.cfg_max     = '0;
    tick(3);
    reset = 1'b0;
    tick(1);

    // Reset state
    chk("rst_count0", cnt(0), 0);
    chk("rst_count1", cnt(1), 0);
    chk("rst_event", 64'(bus_if.enc_event), 0);
    chk("rst_left", 64'(bus_if.enc_left), 0);
    chk("rst_err", 64'(bus_if.enc_err), 0);

    // First transition latency: 2 sync + 4 filter + 1 = event on the 7th edge
    e0 = ev_tot[0];
    e1 = ev_tot[1];
    drive(0, 2'b01);
    tick(6);
    chk("lat_early", 64'(bus_if.enc_event[0]), 0);
    tick(1);
    chk("lat_event", 64'(bus_if.enc_event[0]), 1);
    chk("lat_count", cnt(0), 1);
    tick(2);
    for (int i = 1; i < 4; i++) move(0, rseq[i]);
    for (int c = 0; c < 3; c++) for (int i = 0; i < 4; i++) move(0, rseq[i]);
    chk("x4_count0", cnt(0), 16);
    chk("x4_events0", ev_tot[0] - e0, 16);
    chk("x4_count1", cnt(1), 0);
    chk("x4_events1", ev_tot[1] - e1, 0);
    chk("x4_left", 64'(bus_if.enc_left[0]), 0);

    // x1: three left cycles then boundary jitter nets zero
    load(2'd0, 4'd1, 1'b0, 16'sh8000, 16'sh7FFF);
    chk("x1_load_count0", cnt(0), 0);
    for (int c = 0; c < 3; c++) for (int i = 0; i < 4; i++) move(0, lseq[i]);
    chk("x1_count", cnt(0), -3);
    chk("x1_left", 64'(bus_if.enc_left[0]), 1);
    for (int j = 0; j < 5; j++) begin
      move(0, 2'b10);
      move(0, 2'b00);
    end
    chk("x1_jitter", cnt(0), -3);

    // x2: three left cycles
    load(2'd1, 4'd1, 1'b0, 16'sh8000, 16'sh7FFF);
    for (int c = 0; c < 3; c++) for (int i = 0; i < 4; i++) move(0, lseq[i]);
    chk("x2_count", cnt(0), -6);

    // Saturation at max=5 with step 3
    load(2'd2, 4'd3, 1'b0, -16'sd2, 16'sd5);
    chk("sat_load", cnt(0), 0);
    for (int i = 0; i < 4; i++) begin
      move(0, rseq[i]);
      chk($sformatf("sat_step%0d", i), cnt(0), 64'(exp_sat[i]));
    end

    // Wrap within [-2,5] with step 3, both directions
    load(2'd2, 4'd3, 1'b1, -16'sd2, 16'sd5);
    for (int i = 0; i < 5; i++) begin
      move(0, rseq[i % 4]);
      chk($sformatf("wrap_step%0d", i), cnt(0), 64'(exp_wrap[i]));
    end
    move(0, 2'b00);
    chk("wrap_left", cnt(0), 4);

    // Short glitch on A is filtered out
    load(2'd2, 4'd1, 1'b0, 16'sh8000, 16'sh7FFF);
    e0 = ev_tot[0];
    bus_if.enc_a[0] = 1'b1;
    tick(2);
    bus_if.enc_a[0] = 1'b0;
    tick(12);
    chk("glitch_events", ev_tot[0] - e0, 0);
    chk("glitch_count", cnt(0), 0);

    // Double-bit change flags error without counting; clear removes it
    move(0, 2'b11);
    chk("illegal_err", 64'(bus_if.enc_err[0]), 1);
    chk("illegal_count", cnt(0), 0);
    chk("illegal_events", ev_tot[0] - e0, 0);
    chk("illegal_err_ch1", 64'(bus_if.enc_err[1]), 0);
    bus_if.clear_count[0] = 1'b1;
    tick(1);
    bus_if.clear_count[0] = 1'b0;
    chk("clear_err", 64'(bus_if.enc_err[0]), 0);

    // Load clamps counts into range; an inverted range is ignored
    load(2'd2, 4'd1, 1'b0, 16'sd10, 16'sd20);
    chk("load_count0", cnt(0), 10);
    chk("load_count1", cnt(1), 10);
    load(2'd0, 4'd5, 1'b1, 16'sd30, 16'sd5);
    chk("badload_count0", cnt(0), 10);
    move(1, 2'b01);
    chk("badload_cfg", cnt(1), 11);

    // Event coincident with clear: pulse survives, step discarded
    load(2'd2, 4'd1, 1'b0, -16'sd100, 16'sd100);
    move(0, 2'b10);
    chk("pre_clear_count", cnt(0), 1);
    drive(0, 2'b00);
    tick(6);
    bus_if.clear_count[0] = 1'b1;
    tick(1);
    chk("clr_ev_event", 64'(bus_if.enc_event[0]), 1);
    chk("clr_ev_count", cnt(0), 0);
    bus_if.clear_count[0] = 1'b0;
    tick(2);
    chk("clr_ev_hold", cnt(0), 0);

    // Reset in the middle of a filter window
    drive(1, 2'b11);
    tick(3);
    reset = 1'b1;
    #1;
    chk("midrst_count0", cnt(0), 0);
    chk("midrst_count1", cnt(1), 0);
    chk("midrst_event", 64'(bus_if.enc_event), 0);
    chk("midrst_err", 64'(bus_if.enc_err), 0);
    chk("midrst_left", 64'(bus_if.enc_left), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
